// File: rtl/map_pkg.sv
// Shared types and constants for the routing-map SRAM arbiter: FSM encoding,
// map cell codes and the round-robin tie resolver.
package map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_e;

  localparam logic [7:0] CELL_FREE     = 8'd238;
  localparam logic [7:0] CELL_BLOCK    = 8'd255;
  localparam logic [7:0] CELL_NET2     = 8'd17;
  localparam logic [7:0] PIN_BASE_ADDR = 8'd128;

  localparam int STAT_CYC_W  = 16;
  localparam int STAT_CONF_W = 8;

  // Returns the index of the master to grant; on a tie the one that did not own last.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_owner);
    if (req0 && req1) return ~last_owner;
    return req1;
  endfunction

endpackage

// File: rtl/map_sram_arbiter.sv
// Two-master hold-lock arbiter for the single-port routing-map SRAM.
// Optional per-master ownership and conflict counters under MAP_ARB_STATS_EN.
module map_sram_arbiter
  import map_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req,
  output logic                   m0_gnt,
  input  logic                   m0_cs,
  input  logic                   m0_we,
  input  logic [ADDR_WIDTH-1:0]  m0_addr,
  input  logic [DATA_WIDTH-1:0]  m0_wdata,
  input  logic                   m1_req,
  output logic                   m1_gnt,
  input  logic                   m1_cs,
  input  logic                   m1_we,
  input  logic [ADDR_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0]  m1_wdata,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_wdata,
  input  logic [DATA_WIDTH-1:0]  sram_rdata,
`ifdef MAP_ARB_STATS_EN
  output logic [STAT_CYC_W-1:0]  m0_cycles,
  output logic [STAT_CYC_W-1:0]  m1_cycles,
  output logic [STAT_CONF_W-1:0] conflict_cnt,
`endif
  output logic                   busy
);

  // state   | meaning
  // IDLE    | no owner, arbitrate pending requests
  // OWN0    | router owns the SRAM
  // OWN1    | host port owns the SRAM
  // TURN    | handover gap, lets the last read return before a new owner

  localparam int TURN_W    = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int TURN_LOAD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  arb_state_e        state_q;
  logic              m0_gnt_q;
  logic              m1_gnt_q;
  logic              last_owner_q;
  logic [TURN_W-1:0] turn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      last_owner_q <= 1'b1;
      turn_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            if (rr_pick(m0_req, m1_req, last_owner_q)) begin
              state_q  <= ST_OWN1;
              m1_gnt_q <= 1'b1;
            end else begin
              state_q  <= ST_OWN0;
              m0_gnt_q <= 1'b1;
            end
          end
        end
        ST_OWN0: begin
          if (!m0_req) begin
            state_q      <= ST_TURN;
            m0_gnt_q     <= 1'b0;
            last_owner_q <= 1'b0;
            turn_q       <= TURN_W'(TURN_LOAD);
          end
        end
        ST_OWN1: begin
          if (!m1_req) begin
            state_q      <= ST_TURN;
            m1_gnt_q     <= 1'b0;
            last_owner_q <= 1'b1;
            turn_q       <= TURN_W'(TURN_LOAD);
          end
        end
        ST_TURN: begin
          if (turn_q == '0) state_q <= ST_IDLE;
          else              turn_q  <= turn_q - 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          m0_gnt_q <= 1'b0;
          m1_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  // Owner's bus goes straight through; everything else sees an idle, zeroed bus.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (m0_gnt_q) begin
      sram_cs    = m0_cs;
      sram_we    = m0_we;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end else if (m1_gnt_q) begin
      sram_cs    = m1_cs;
      sram_we    = m1_we;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end
  end

  assign m0_gnt = m0_gnt_q;
  assign m1_gnt = m1_gnt_q;
  assign rdata  = sram_rdata;
  assign busy   = (state_q != ST_IDLE);

`ifdef MAP_ARB_STATS_EN
  logic [STAT_CYC_W-1:0]  m0_cycles_q;
  logic [STAT_CYC_W-1:0]  m1_cycles_q;
  logic [STAT_CONF_W-1:0] conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_cycles_q <= '0;
      m1_cycles_q <= '0;
      conflict_q  <= '0;
    end else begin
      if (state_q == ST_OWN0 && m0_cycles_q != '1) m0_cycles_q <= m0_cycles_q + 1'b1;
      if (state_q == ST_OWN1 && m1_cycles_q != '1) m1_cycles_q <= m1_cycles_q + 1'b1;
      if (state_q == ST_IDLE && m0_req && m1_req && conflict_q != '1)
        conflict_q <= conflict_q + 1'b1;
    end
  end

  assign m0_cycles    = m0_cycles_q;
  assign m1_cycles    = m1_cycles_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_map_sram_arbiter.sv
// Directed bench for map_sram_arbiter with a 1-cycle-latency SRAM model.
// Counter checks are compiled in when MAP_ARB_STATS_EN is defined.
module tb_map_sram_arbiter;
  import map_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_cs, m0_we, m1_req, m1_cs, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m1_gnt, busy, sram_cs, sram_we;
  logic [7:0] rdata, sram_addr, sram_wdata, sram_rdata;
`ifdef MAP_ARB_STATS_EN
  logic [15:0] m0_cycles, m1_cycles;
  logic [7:0]  conflict_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  map_sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TURN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_cs(m0_cs), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_cs(m1_cs), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .rdata(rdata), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
`ifdef MAP_ARB_STATS_EN
    .m0_cycles(m0_cycles), .m1_cycles(m1_cycles), .conflict_cnt(conflict_cnt),
`endif
    .busy(busy)
  );

  logic [7:0] mem [256];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         rd_q <= mem[sram_addr];
    end
  end
  assign sram_rdata = rd_q;

  typedef struct packed {
    logic       r0, cs0, we0;
    logic [7:0] a0, d0;
    logic       r1, cs1, we1;
    logic [7:0] a1, d1;
    logic       eg0, eg1, ebusy, ecs, ewe;
    logic [7:0] eaddr, ewd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_cs = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_cs = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  function automatic logic [20:0] obs();
    return {m0_gnt, m1_gnt, busy, sram_cs, sram_we, sram_addr, sram_wdata};
  endfunction

  initial begin
    // r0 cs0 we0 a0 d0 | r1 cs1 we1 a1 d1 | g0 g1 busy cs we addr wdata
    tbl[0]  = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,0,0,0,0,8'd0,8'h00};
    tbl[1]  = '{0,0,0,8'd0,8'h00,   1,1,1,8'd128,8'h05, 0,0,0,0,0,8'd0,8'h00};
    tbl[2]  = '{0,0,0,8'd0,8'h00,   1,1,1,8'd128,8'h05, 0,1,1,1,1,8'd128,8'h05};
    tbl[3]  = '{0,1,1,8'd3,8'hAA,   1,1,0,8'd129,8'h00, 0,1,1,1,0,8'd129,8'h00};
    tbl[4]  = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,1,1,0,0,8'd0,8'h00};
    tbl[5]  = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,0,1,0,0,8'd0,8'h00};
    tbl[6]  = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,0,1,0,0,8'd0,8'h00};
    tbl[7]  = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,0,0,0,0,8'd0,8'h00};
    tbl[8]  = '{1,1,1,8'd10,8'h11,  1,1,1,8'd3,8'h99,   0,0,0,0,0,8'd0,8'h00};
    tbl[9]  = '{1,1,1,8'd10,8'h11,  1,1,1,8'd3,8'h99,   1,0,1,1,1,8'd10,8'h11};
    tbl[10] = '{1,1,0,8'd129,8'h00, 1,1,1,8'd3,8'h99,   1,0,1,1,0,8'd129,8'h00};
    tbl[11] = '{0,0,0,8'd0,8'h00,   1,1,1,8'd3,8'h99,   1,0,1,0,0,8'd0,8'h00};
    tbl[12] = '{0,0,0,8'd0,8'h00,   1,1,1,8'd3,8'h99,   0,0,1,0,0,8'd0,8'h00};
    tbl[13] = '{0,0,0,8'd0,8'h00,   1,1,1,8'd3,8'h99,   0,0,1,0,0,8'd0,8'h00};
    tbl[14] = '{0,0,0,8'd0,8'h00,   1,1,0,8'd3,8'h00,   0,0,0,0,0,8'd0,8'h00};
    tbl[15] = '{0,0,0,8'd0,8'h00,   1,1,0,8'd3,8'h00,   0,1,1,1,0,8'd3,8'h00};
    tbl[16] = '{0,0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,   0,1,1,0,0,8'd0,8'h00};

    for (int i = 0; i < 256; i++) mem[i] = CELL_FREE;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("reset_state", 32'(obs()), 32'h0);

    for (int i = 0; i < 17; i++) begin
      m0_req = tbl[i].r0; m0_cs = tbl[i].cs0; m0_we = tbl[i].we0;
      m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
      m1_req = tbl[i].r1; m1_cs = tbl[i].cs1; m1_we = tbl[i].we1;
      m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({tbl[i].eg0, tbl[i].eg1, tbl[i].ebusy, tbl[i].ecs, tbl[i].ewe,
               tbl[i].eaddr, tbl[i].ewd}));
      cyc();
    end
    chk("mem_pin128", 32'(mem[PIN_BASE_ADDR]), 32'h05);
    chk("mem_10", 32'(mem[10]), 32'h11);
    chk("mem_3_untouched", 32'(mem[3]), 32'(CELL_FREE));

    // Last read before release must still return during the handover gap.
    idle_inputs();
    repeat (3) cyc();
    m0_req = 1; m1_req = 1;
    #1 chk("h1_idle_tie", 32'({m0_gnt, m1_gnt}), 32'h0);
    cyc();
    m0_cs = 1; m0_we = 1; m0_addr = 8'd129; m0_wdata = 8'h22;
    #1 chk("h1_m0_first", 32'({m0_gnt, m1_gnt}), 32'h2);
    cyc();
    m0_we = 0;
    cyc();
    m0_req = 0; m0_cs = 0; m0_addr = 0; m0_wdata = 0;
    #1 chk("h1_last_own", 32'(m0_gnt), 32'h1);
    for (int t = 0; t < 2; t++) begin
      cyc();
      #1;
      chk($sformatf("h1_turn%0d_rdata", t), 32'(rdata), 32'h22);
      chk($sformatf("h1_turn%0d_bus", t), 32'({sram_cs, sram_we, m0_gnt, m1_gnt, busy}), 32'h01);
    end
    cyc();
    #1 chk("h1_idle_after_turn", 32'({m1_gnt, busy}), 32'h0);
    cyc();
    #1 chk("h1_m1_granted", 32'({m0_gnt, m1_gnt, busy}), 32'h3);

    // Reset while the host owns; afterwards the router must win the tie again.
    m1_cs = 1; m1_we = 0; m1_addr = 8'd7;
    m0_req = 1; reset = 1;
    cyc();
    #1 chk("h2_reset_drop", 32'({m0_gnt, m1_gnt, busy, sram_cs}), 32'h0);
    reset = 0;
    cyc();
    #1 chk("h2_first_tie_m0", 32'({m0_gnt, m1_gnt}), 32'h2);
    chk("h2_bus_follows_m0", 32'({sram_cs, sram_addr}), 32'h000);

`ifdef MAP_ARB_STATS_EN
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
    m0_req = 1; m1_req = 1;
    cyc();
    repeat (20) cyc();
    #1 chk("st_m1_waits", 32'({m0_gnt, m1_gnt}), 32'h2);
    repeat (19) cyc();
    m0_req = 0;
    cyc();
    m0_req = 1;
    repeat (2) cyc();
    cyc();
    #1 chk("st_m1_rr_win", 32'({m0_gnt, m1_gnt}), 32'h1);
    repeat (9) cyc();
    m1_req = 0;
    cyc();
    m1_req = 1;
    repeat (2) cyc();
    cyc();
    #1;
    chk("st_m0_back", 32'({m0_gnt, m1_gnt}), 32'h2);
    chk("st_m0_cycles", 32'(m0_cycles), 32'd40);
    chk("st_m1_cycles", 32'(m1_cycles), 32'd10);
    chk("st_conflicts", 32'(conflict_cnt), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
